pll_lock_sequencer: RTL and testbench

- Supervises the core PLL from its free-running reference clock domain.
- Synchronises the PLL's asynchronous locked output and drives the PLL rst input.
- Holds core_reset until lock has been continuously stable; on lock loss or lock timeout, re-resets the PLL.
- Sits between the PLL wrapper and the reset tree of every domain clocked by the PLL outputs.

---
 rtl/pll_lock_sequencer.sv | 129 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: synchronises pll_locked, pulses pll_rst, and holds core_reset
// until lock has been continuously stable; re-resets the PLL on lock loss or timeout.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 74250,
  parameter int RELOCK_TIMEOUT     = 742500
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  localparam logic [1:0] ST_PLL_RESET = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABILIZE = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam int RST_W = $clog2(PLL_RST_CYCLES) + 1;
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int TO_W  = $clog2(RELOCK_TIMEOUT) + 1;

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RELOCK_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   locked_s;
  logic [1:0]             state_q, state_d;
  logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
  logic [STB_W-1:0]       stb_cnt_q, stb_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   lost_q, lost_d;
  logic [7:0]             relock_q, relock_d;
  logic                   to_err_q, to_err_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   core_reset_q, core_reset_d;
  logic                   ready_q, ready_d;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
  assign locked_s = sync_q[SYNC_STAGES-1];

  // Counters default to zero, so any state change clears them; they only
  // advance while the FSM stays put, and each exits at its last value.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    stb_cnt_d = '0;
    to_cnt_d  = '0;
    lost_d    = 1'b0;
    relock_d  = relock_q;
    to_err_d  = to_err_q;
    case (state_q)
      ST_PLL_RESET: begin
        if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        else                       rst_cnt_d = rst_cnt_q + 1'b1;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABILIZE;
        end else if (to_cnt_q == TO_LAST) begin
          to_err_d = 1'b1;
          state_d  = ST_PLL_RESET;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_STABILIZE: begin
        if (!locked_s)                  state_d = ST_WAIT_LOCK;
        else if (stb_cnt_q == STB_LAST) state_d = ST_RUN;
        else                            stb_cnt_d = stb_cnt_q + 1'b1;
      end
      ST_RUN: begin
        // Loss is latched for one edge before acting, giving a fixed
        // SYNC_STAGES+1 edge detection latency from the raw input.
        if (lost_q) begin
          state_d = ST_PLL_RESET;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end else begin
          lost_d = ~locked_s;
        end
      end
      default: state_d = ST_PLL_RESET;
    endcase
    pll_rst_d    = (state_d == ST_PLL_RESET);
    core_reset_d = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= ST_PLL_RESET;
      rst_cnt_q    <= '0;
      stb_cnt_q    <= '0;
      to_cnt_q     <= '0;
      lost_q       <= 1'b0;
      relock_q     <= 8'd0;
      to_err_q     <= 1'b0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      to_cnt_q     <= to_cnt_d;
      lost_q       <= lost_d;
      relock_q     <= relock_d;
      to_err_q     <= to_err_d;
      pll_rst_q    <= pll_rst_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign core_reset   = core_reset_q;
  assign ready        = ready_q;
  assign relock_count = relock_q;
  assign timeout_err  = to_err_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed test-plan scenarios plus randomized lock
// traffic, all outputs compared every edge against a sample-history reference model.
module tb_pll_lock_sequencer;
  localparam int SS = 2, PRC = 4, LSC = 8, RT = 32;
  localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, core_reset, ready, timeout_err;
  logic [7:0] relock_count;

  pll_lock_sequencer #(
    .SYNC_STAGES(SS), .PLL_RST_CYCLES(PRC),
    .LOCK_STABLE_CYCLES(LSC), .RELOCK_TIMEOUT(RT)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .core_reset(core_reset), .ready(ready), .relock_count(relock_count),
    .timeout_err(timeout_err)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: phase + elapsed count; hist[k] = pll_locked sampled k edges ago.
  int m_st = M_RST, m_cnt = 0, m_prev = M_RST, m_relock = 0, m_to = 0;
  int hist[$];

  task automatic model_step(input logic r, input logic l);
    int ls, nst;
    bit lost;
    hist.push_front(l ? 1 : 0);
    while (hist.size() > SS + 2) void'(hist.pop_back());
    if (r) begin
      m_st = M_RST; m_cnt = 0; m_prev = M_RST; m_relock = 0; m_to = 0;
      foreach (hist[i]) hist[i] = 0;
      return;
    end
    ls   = hist[SS];
    lost = (m_prev == M_RUN) && (hist[SS+1] == 0);
    nst  = m_st;
    case (m_st)
      M_RST:  if (m_cnt == PRC - 1) nst = M_WAIT; else m_cnt++;
      M_WAIT: if (ls == 1) nst = M_STAB;
              else if (m_cnt == RT - 1) begin m_to = 1; nst = M_RST; end
              else m_cnt++;
      M_STAB: if (ls == 0) nst = M_WAIT;
              else if (m_cnt == LSC - 1) nst = M_RUN;
              else m_cnt++;
      default: if (lost) begin nst = M_RST; if (m_relock < 255) m_relock++; end
    endcase
    m_prev = m_st;
    if (nst != m_st) m_cnt = 0;
    m_st = nst;
  endtask

  task automatic tick();
    @(posedge refclk);
    model_step(rst, pll_locked);
    #1;
    chk("pll_rst", pll_rst, (m_st == M_RST) ? 1 : 0);
    chk("core_reset", core_reset, (m_st != M_RUN) ? 1 : 0);
    chk("ready", ready, (m_st == M_RUN) ? 1 : 0);
    chk("relock_count", relock_count, m_relock);
    chk("timeout_err", timeout_err, m_to);
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (ready !== 1'b1 && n < limit) begin tick(); n++; end
    chk("wait_ready_bound", ready, 1);
  endtask

  task automatic lose_and_relock();
    pll_locked = 1'b0;
    repeat (8) tick();
    pll_locked = 1'b1;
    wait_ready(60);
  endtask

  initial begin
    int hold;
    repeat (SS + 2) hist.push_back(0);

    // 1: reset, then pll_rst high for exactly PRC edges
    rst = 1'b1; pll_locked = 1'b0;
    repeat (3) tick();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ready", ready, 0);
    rst = 1'b0;
    for (int i = 1; i <= PRC; i++) begin
      tick();
      chk("pll_rst_pulse", pll_rst, (i < PRC) ? 1 : 0);
    end

    // 2: lock acquired, ready after edge SS+LSC
    pll_locked = 1'b1;
    tick();
    for (int k = 1; k <= SS + LSC; k++) begin
      tick();
      if (k == SS + LSC - 1) chk("ready_edge9", ready, 0);
      if (k == SS + LSC) begin
        chk("ready_edge10", ready, 1);
        chk("core_reset_edge10", core_reset, 0);
        chk("relock_after_acq", relock_count, 0);
      end
    end

    // 4: lock loss in RUN, detected on edge SS+1
    pll_locked = 1'b0;
    tick();
    for (int k = 1; k <= SS + 1; k++) begin
      tick();
      chk("loss_core_reset", core_reset, (k == SS + 1) ? 1 : 0);
    end
    chk("loss_pll_rst", pll_rst, 1);
    chk("loss_relock", relock_count, 1);

    // 3: one-cycle dropout during STABILIZE restarts the stable window
    repeat (6) tick();
    pll_locked = 1'b1;
    repeat (SS + 1 + 5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (4) tick();
    chk("dropout_ready_low", ready, 0);
    wait_ready(60);
    chk("dropout_timeout_err", timeout_err, 0);

    // 4b: saturation of relock_count
    for (int i = 0; i < 260; i++) lose_and_relock();
    chk("relock_saturated", relock_count, 255);

    // 5: no lock after reset -> repeated timeouts, sticky flag
    rst = 1'b1; pll_locked = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (PRC + RT - 1) tick();
    chk("pre_timeout_err", timeout_err, 0);
    tick();
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_pll_rst", pll_rst, 1);
    repeat (3 * (PRC + RT)) tick();
    chk("timeout_sticky", timeout_err, 1);

    // 6: rst in RUN clears relock_count and timeout_err
    pll_locked = 1'b1;
    wait_ready(60);
    repeat (3) lose_and_relock();
    chk("pre_rst_relock", relock_count, 3);
    chk("pre_rst_timeout", timeout_err, 1);
    rst = 1'b1;
    tick();
    chk("rst_run_core_reset", core_reset, 1);
    chk("rst_run_ready", ready, 0);
    chk("rst_run_pll_rst", pll_rst, 1);
    chk("rst_run_relock", relock_count, 0);
    chk("rst_run_timeout", timeout_err, 0);
    rst = 1'b0;

    // Random lock traffic with occasional resets
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        pll_locked = ~pll_locked;
        hold = pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 50);
      end
      hold--;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
